// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Stretches a reset source and releases NUM_CH downstream reset channels
//   one after another. Channel 0 is held for STRETCH_CYC edges after the
//   reset source drops. Each following channel is released GAP_CYC edges
//   after the one before it.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_i     in   synchronous active-high reset, primary reset source
//   sw_rst_i  in   synchronous software reset request (does not clear err_o)
//   ack_i     in   [NUM_CH] per-channel "out of reset" acknowledge
//   rst_o     out  [NUM_CH] per-channel stretched reset, active-high
//   busy_o    out  high while any rst_o bit is high
//   done_o    out  high once every channel is released (always ~busy_o)
//   err_o     out  sticky acknowledge-timeout flag
//
// Configuration:
//   RST_SEQ_ACK_EN  When defined, each release waits for that channel's
//                   acknowledge before the gap to the next channel starts.
//                   A missing ack is replaced by a timeout of ACK_TIMEOUT
//                   edges, which also sets err_o. When undefined, ack_i is
//                   ignored and err_o is tied low.
// ---------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int STRETCH_CYC = 16,
    parameter int GAP_CYC     = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              sw_rst_i,
    input  logic [NUM_CH-1:0] ack_i,
    output logic [NUM_CH-1:0] rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [15:0] STRETCH_LAST = 16'(STRETCH_CYC - 1);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYC - 1);
    localparam logic [15:0] CNT_MAX      = 16'hFFFF;
    localparam logic [3:0]  LAST_IDX     = 4'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ASSERT,
        WAIT,
        DONE
    } state_t;

    state_t            r_state;
    logic [15:0]       r_cnt;
    logic [3:0]        r_idx;
    logic [NUM_CH-1:0] r_rst;
    logic              r_busy;
    logic              r_done;

`ifdef RST_SEQ_ACK_EN
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    logic        r_ackPend;
    logic [15:0] r_tmo;
    logic        r_err;
    logic        w_ackSel;

    // Acknowledge of the most recently released channel (r_idx).
    always_comb begin
        w_ackSel = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_idx == 4'(k)) begin
                w_ackSel = ack_i[k];
            end
        end
    end
`else
    logic w_unusedAck;
    assign w_unusedAck = ^{ack_i, 16'(ACK_TIMEOUT)};
`endif

    // Sequencer FSM. In WAIT, r_idx is the last channel already released
    // and the gap counter runs toward releasing channel r_idx+1. With
    // acknowledge gating, r_ackPend holds the gap counter at zero until
    // the ack for channel r_idx arrives or its timeout expires; the final
    // channel's ack is what moves the state into DONE.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state <= ASSERT;
            r_cnt   <= 16'd0;
            r_idx   <= 4'd0;
            r_rst   <= '1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
`ifdef RST_SEQ_ACK_EN
            r_ackPend <= 1'b0;
            r_tmo     <= 16'd0;
            r_err     <= 1'b0;
`endif
        end else if (sw_rst_i) begin
            r_state <= ASSERT;
            r_cnt   <= 16'd0;
            r_idx   <= 4'd0;
            r_rst   <= '1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
`ifdef RST_SEQ_ACK_EN
            r_ackPend <= 1'b0;
            r_tmo     <= 16'd0;
`endif
        end else begin
            case (r_state)
                ASSERT: begin
                    if (r_cnt == STRETCH_LAST) begin
                        r_rst[0] <= 1'b0;
                        r_idx    <= 4'd0;
                        r_cnt    <= 16'd0;
`ifdef RST_SEQ_ACK_EN
                        r_ackPend <= 1'b1;
                        r_tmo     <= 16'd0;
                        r_state   <= WAIT;
                        if (NUM_CH == 1) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end
`else
                        if (NUM_CH == 1) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
`endif
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                WAIT: begin
`ifdef RST_SEQ_ACK_EN
                    if (r_ackPend) begin
                        if (w_ackSel || (r_tmo == TMO_LAST)) begin
                            if (!w_ackSel) begin
                                r_err <= 1'b1;
                            end
                            r_ackPend <= 1'b0;
                            r_tmo     <= 16'd0;
                            r_cnt     <= 16'd0;
                            if (r_idx == LAST_IDX) begin
                                r_state <= DONE;
                            end
                        end else if (r_tmo != CNT_MAX) begin
                            r_tmo <= r_tmo + 16'd1;
                        end
                    end else
`endif
                    begin
                        if (r_cnt == GAP_LAST) begin
                            for (int k = 1; k < NUM_CH; k++) begin
                                if (4'(k) == r_idx + 4'd1) begin
                                    r_rst[k] <= 1'b0;
                                end
                            end
                            r_idx <= r_idx + 4'd1;
                            r_cnt <= 16'd0;
                            if (r_idx + 4'd1 == LAST_IDX) begin
                                r_busy <= 1'b0;
                                r_done <= 1'b1;
`ifndef RST_SEQ_ACK_EN
                                r_state <= DONE;
`endif
                            end
`ifdef RST_SEQ_ACK_EN
                            r_ackPend <= 1'b1;
                            r_tmo     <= 16'd0;
`endif
                        end else if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign rst_o  = r_rst;
    assign busy_o = r_busy;
    assign done_o = r_done;
`ifdef RST_SEQ_ACK_EN
    assign err_o  = r_err;
`else
    assign err_o  = 1'b0;
`endif

endmodule
